// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit for the multicycle MIPS datapath.
// Radix-2 Booth multiply and restoring divide, one iteration per clock, results in HI/LO.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             MultCtrl,
  input  logic             DivCtrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  localparam int CW  = $clog2(WIDTH);
  localparam int AW  = 2 * WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MULT,
    S_DIV,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dz_q, dz_d;

  // Multiply view of acc: {hi[WIDTH], lo[WIDTH], booth q-1}.
  // Divide view of acc:   {remainder[WIDTH+1], quotient/dividend[WIDTH]}.
  logic [WIDTH:0]   booth_hi_ext;
  logic [WIDTH:0]   booth_m_ext;
  logic [WIDTH:0]   booth_sum;
  logic [AW-1:0]    booth_next;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_trial;
  logic [AW-1:0]    div_next;
  logic [WIDTH-1:0] quo_mag;
  logic [WIDTH-1:0] rem_mag;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             last_iter;

  assign abs_a     = A[WIDTH-1] ? -A : A;
  assign abs_b     = B[WIDTH-1] ? -B : B;
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  // The partial sum is formed one bit wider so that subtracting the most
  // negative multiplicand cannot wrap before the arithmetic shift.
  always_comb begin
    booth_hi_ext = {acc_q[AW-1], acc_q[AW-1:WIDTH+1]};
    booth_m_ext  = {opnd_q[WIDTH-1], opnd_q};
    case (acc_q[1:0])
      2'b01:   booth_sum = booth_hi_ext + booth_m_ext;
      2'b10:   booth_sum = booth_hi_ext - booth_m_ext;
      default: booth_sum = booth_hi_ext;
    endcase
    booth_next = {booth_sum, acc_q[WIDTH:1]};
  end

  always_comb begin
    rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_trial = rem_shift - {1'b0, opnd_q};
    if (!rem_trial[WIDTH]) begin
      div_next = {rem_trial, acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {rem_shift, acc_q[WIDTH-2:0], 1'b0};
    end
    quo_mag = div_next[WIDTH-1:0];
    rem_mag = div_next[2*WIDTH-1:WIDTH];
  end

  // NOTE: every next-state signal takes its held value first, so no path
  // through this block leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dz_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (MultCtrl) begin
          state_d = S_MULT;
          cnt_d   = '0;
          acc_d   = {{WIDTH{1'b0}}, B, 1'b0};
          opnd_d  = A;
        end else if (DivCtrl) begin
          if (B == '0) begin
            state_d = S_DONE;
            dz_d    = 1'b1;
          end else begin
            state_d   = S_DIV;
            cnt_d     = '0;
            acc_d     = {{(WIDTH + 1){1'b0}}, abs_a};
            opnd_d    = abs_b;
            neg_quo_d = A[WIDTH-1] ^ B[WIDTH-1];
            neg_rem_d = A[WIDTH-1];
          end
        end
      end

      S_MULT: begin
        acc_d = booth_next;
        cnt_d = cnt_q + 1'b1;
        if (last_iter) begin
          state_d = S_DONE;
          hi_d    = booth_next[AW-1:WIDTH+1];
          lo_d    = booth_next[WIDTH:1];
        end
      end

      S_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q + 1'b1;
        if (last_iter) begin
          state_d = S_DONE;
          lo_d    = neg_quo_q ? -quo_mag : quo_mag;
          hi_d    = neg_rem_q ? -rem_mag : rem_mag;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dz_q      <= dz_d;
    end
  end

  assign HI      = hi_q;
  assign LO      = lo_q;
  assign Busy    = (state_q == S_MULT) || (state_q == S_DIV);
  assign Done    = (state_q == S_DONE);
  assign DivZero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, hand-written
// corner sequences and random operations scored against an arithmetic model.
module tb_mult_div_unit;

  logic        clock;
  logic        reset;
  logic        MultCtrl;
  logic        DivCtrl;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        Busy;
  logic        Done;
  logic        DivZero;

  int total = 0;
  int bad   = 0;

  // Architectural HI/LO as the model sees them.
  logic [31:0] model_hi = 32'h0;
  logic [31:0] model_lo = 32'h0;

  typedef struct {
    bit          mul;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    bit          dz;
  } vec_t;

  vec_t vecs[$];

  mult_div_unit #(.WIDTH(32)) dut (
    .clock  (clock),
    .reset  (reset),
    .MultCtrl(MultCtrl),
    .DivCtrl(DivCtrl),
    .A      (A),
    .B      (B),
    .HI     (HI),
    .LO     (LO),
    .Busy   (Busy),
    .Done   (Done),
    .DivZero(DivZero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Signed reference computed with 64-bit integer arithmetic.
  task automatic model_op(input bit mul, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo, output bit dz);
    longint sa;
    longint sb;
    logic [63:0] p;
    logic [63:0] q;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    hi = model_hi;
    lo = model_lo;
    if (mul) begin
      p  = sa * sb;
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 32'h0) begin
      dz = 1'b1;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      lo = q[31:0];
      hi = r[31:0];
    end
  endtask

  // Starts one operation and watches a fixed 40-cycle window after the
  // accepting edge; index i is the negedge following edge N+i.
  task automatic run_op(input string tag, input bit mul, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input bit exp_dz,
                        input bit hold, input int pulse_at);
    int busy_cnt;
    int done_cnt;
    int dz_cnt;
    int done_at;
    logic [31:0] hi_s;
    logic [31:0] lo_s;
    busy_cnt = 0;
    done_cnt = 0;
    dz_cnt   = 0;
    done_at  = -1;
    hi_s     = 32'hx;
    lo_s     = 32'hx;
    @(negedge clock);
    A        = a;
    B        = b;
    MultCtrl = mul;
    DivCtrl  = !mul;
    @(posedge clock);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (Busy) busy_cnt++;
      if (DivZero) dz_cnt++;
      if (Done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = i;
          hi_s    = HI;
          lo_s    = LO;
        end
      end
      if (i == 0) begin
        A = $urandom;
        B = $urandom;
        if (!hold) begin
          MultCtrl = 1'b0;
          DivCtrl  = 1'b0;
        end
      end
      if (hold && Done) begin
        MultCtrl = 1'b0;
        DivCtrl  = 1'b0;
      end
      if (i == pulse_at) DivCtrl = 1'b1;
      if (i == pulse_at + 1) DivCtrl = 1'b0;
    end
    MultCtrl = 1'b0;
    DivCtrl  = 1'b0;
    check({tag, " done_count"}, 64'(done_cnt), 64'd1);
    check({tag, " done_cycle"}, 64'(done_at), exp_dz ? 64'd0 : 64'd32);
    check({tag, " busy_cycles"}, 64'(busy_cnt), exp_dz ? 64'd0 : 64'd32);
    check({tag, " divzero_count"}, 64'(dz_cnt), exp_dz ? 64'd1 : 64'd0);
    check({tag, " HI"}, 64'(hi_s), 64'(exp_hi));
    check({tag, " LO"}, 64'(lo_s), 64'(exp_lo));
    model_hi = exp_hi;
    model_lo = exp_lo;
  endtask

  initial begin
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    bit          e_dz;
    bit          mul;
    logic [31:0] ra;
    logic [31:0] rb;
    int          late_done;

    vecs.push_back('{1'b1, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0});
    vecs.push_back('{1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0});
    vecs.push_back('{1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0});
    vecs.push_back('{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0});
    vecs.push_back('{1'b1, 32'd0,        32'hFFFFFFFB, 32'h00000000, 32'h00000000, 1'b0});
    vecs.push_back('{1'b0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0});
    vecs.push_back('{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0});
    vecs.push_back('{1'b0, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0});
    vecs.push_back('{1'b0, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 1'b0});
    vecs.push_back('{1'b0, 32'd100,      32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 1'b0});
    vecs.push_back('{1'b0, 32'h00000451, 32'h00000020, 32'h00000011, 32'h00000022, 1'b0});
    vecs.push_back('{1'b0, 32'd5,        32'd0,        32'h00000011, 32'h00000022, 1'b1});

    MultCtrl = 1'b0;
    DivCtrl  = 1'b0;
    A        = 32'h0;
    B        = 32'h0;
    reset    = 1'b1;
    repeat (2) @(negedge clock);
    check("reset HI", 64'(HI), 64'd0);
    check("reset LO", 64'(LO), 64'd0);
    check("reset flags", {61'd0, Busy, Done, DivZero}, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].mul, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].dz, 1'b0, -1);
    end

    // Multiply with MultCtrl held throughout: still exactly one completion.
    run_op("hold_mult", 1'b1, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 1'b1, -1);
    // A divide request in the middle of a multiply is ignored.
    run_op("div_pulse", 1'b1, 32'd6, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF4, 1'b0, 1'b0, 10);

    // Both starts together: the multiply wins.
    @(negedge clock);
    A = 32'd9; B = 32'd5; MultCtrl = 1'b1; DivCtrl = 1'b1;
    @(negedge clock);
    MultCtrl = 1'b0; DivCtrl = 1'b0;
    repeat (33) @(negedge clock);
    check("both_starts LO", 64'(LO), 64'd45);
    check("both_starts HI", 64'(HI), 64'd0);
    repeat (4) @(negedge clock);
    model_hi = 32'd0;
    model_lo = 32'd45;

    // Reset at cycle 15 of a multiply aborts it with immediate effect.
    @(negedge clock);
    A = 32'd1000; B = 32'd1000; MultCtrl = 1'b1;
    @(negedge clock);
    MultCtrl = 1'b0;
    repeat (14) @(negedge clock);
    check("pre_reset busy", 64'(Busy), 64'd1);
    reset = 1'b1;
    #1;
    check("abort HI", 64'(HI), 64'd0);
    check("abort LO", 64'(LO), 64'd0);
    check("abort flags", {61'd0, Busy, Done, DivZero}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    late_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (Done || Busy) late_done++;
    end
    check("abort no_activity", 64'(late_done), 64'd0);
    model_hi = 32'd0;
    model_lo = 32'd0;
    run_op("post_reset", 1'b1, 32'hFFFFFF00, 32'd300, 32'hFFFFFFFF, 32'hFFFED400, 1'b0, 1'b0, -1);

    // Random operations against the arithmetic model.
    for (int n = 0; n < 40; n++) begin
      mul = 1'($urandom_range(0, 1));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) ra = 32'h80000000;
      model_op(mul, ra, rb, e_hi, e_lo, e_dz);
      run_op($sformatf("rand%0d", n), mul, ra, rb, e_hi, e_lo, e_dz, 1'b0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

endmodule
